fifo_read_streamer: RTL and testbench

Read-side controller for synchronous_fifo: drains a programmed burst of words through the FIFO's rd_en/data_out/empty port and presents them on a valid/ready stream. It absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer, so no word is lost under downstream backpressure. It is the consumer-side counterpart to the FIFO writer and sits between synchronous_fifo and any downstream sink.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/stream_skid_buf.sv | 78 +++++++
 rtl/fifo_read_streamer.sv | 113 +++++++++++
 tb/tb_fifo_read_streamer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read streamer.
//   DATA_WIDTH_DEF / LEN_W_DEF : default data and burst-length widths
//   BUF_DEPTH                  : depth of the output buffer
//   rd_state_e                 : read controller FSM states
//   data_t                     : default-width data word
//   has_credit()               : may another FIFO read be issued this cycle
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int LEN_W_DEF      = 8;
    localparam int BUF_DEPTH      = 2;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} rd_state_e;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

    // Words already buffered plus the one returning from the FIFO, minus the
    // one leaving this cycle, must leave room for one more read.
    function automatic logic has_credit(input logic [1:0] occ,
                                        input logic       inflight,
                                        input logic       pop);
        logic [2:0] outstanding;
        outstanding = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return outstanding < 3'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry, in-order output buffer presenting words on a valid/ready stream.
//   clk, rst  : clock and synchronous active-high reset
//   push      : capture data_in this cycle
//   data_in   : word to capture
//   m_valid   : head entry is valid
//   m_data    : head entry
//   m_ready   : downstream accepts the head this cycle
//   occ       : number of entries held (0..2)
module stream_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pop;

    always_comb begin
        pop    = (occ_q != 2'd0) && m_ready;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = data_in;
                else               tail_d = data_in;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged: the new word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d = data_in;
                end else begin
                    head_d = tail_q;
                    tail_d = data_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && occ_q == 2'd2))
                else $error("stream_skid_buf: push into full buffer");
        end
    end

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = head_q;
    assign occ     = occ_q;

endmodule

// File: rtl/fifo_read_streamer.sv
// Drains a programmed burst from a synchronous FIFO onto a valid/ready stream,
// absorbing the FIFO's one-cycle read latency with a two-entry buffer.
//   clk, rst_n     : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   fifo_data_out  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty     : FIFO empty flag
//   fifo_rd_en     : FIFO read strobe
//   start          : launches a burst (accepted only when idle)
//   burst_len      : words in the burst, sampled with start
//   m_valid/m_data : output stream, m_ready is the downstream accept
//   busy           : burst in progress
//   done           : one-cycle completion pulse
//   words_sent     : words accepted downstream in the current or last burst
module fifo_read_streamer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      words_sent
);

    rd_state_e        state_q, state_d;
    logic [LEN_W-1:0] reads_left_q, reads_left_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] words_sent_q, words_sent_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       occ;
    logic             pop;

    // The word read last cycle is on fifo_data_out now and is captured here.
    stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst_n),
        .push    (inflight_q),
        .data_in (fifo_data_out),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .occ     (occ)
    );

    always_comb begin
        state_d      = state_q;
        reads_left_d = reads_left_q;
        len_d        = len_q;
        words_sent_d = words_sent_q;

        pop        = m_valid && m_ready;
        fifo_rd_en = (state_q == RUN) && !fifo_empty && (reads_left_q != '0)
                     && has_credit(occ, inflight_q, pop);
        inflight_d = fifo_rd_en;

        if (fifo_rd_en) reads_left_d = reads_left_q - 1'b1;
        if (pop && (words_sent_q != len_q)) words_sent_d = words_sent_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d        = burst_len;
                    reads_left_d = burst_len;
                    words_sent_d = '0;
                    state_d      = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fifo_rd_en && (reads_left_q == LEN_W'(1))) state_d = FLUSH;
            end
            FLUSH: begin
                // Looking at the post-pop count lets done follow the last pop directly.
                if (words_sent_d == len_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            reads_left_q <= '0;
            len_q        <= '0;
            words_sent_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            reads_left_q <= reads_left_d;
            len_q        <= len_d;
            words_sent_q <= words_sent_d;
            inflight_q   <= inflight_d;
        end
    end

    assign busy       = (state_q == RUN) || (state_q == FLUSH);
    assign done       = (state_q == DONE);
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_read_streamer.sv
module tb_fifo_read_streamer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] fifo_data_out = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic       start = 1'b0;
    logic [7:0] burst_len = 8'h00;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] words_sent;

    fifo_read_streamer #(.DATA_WIDTH(8), .LEN_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .start         (start),
        .burst_len     (burst_len),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .busy          (busy),
        .done          (done),
        .words_sent    (words_sent)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // FIFO contents, expected stream words, and words queued for later pushing.
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic [7:0] pending[$];

    // Per-burst observations.
    int r_done_cyc, r_rd_cnt, r_first_rd, r_last_rd, r_rd_stall;
    int r_vld_cnt, r_vld_first, r_vld_last;
    bit r_busy_at_done, r_busy_before, r_busy_ever;
    logic [7:0] r_ws_at_done, r_data_stall_end;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Advance one clock; the FIFO model pops on a read strobe seen at the edge.
    task automatic tick();
        logic rd;
        @(posedge clk);
        rd = fifo_rd_en;
        #1;
        if (rd && fq.size() > 0) fifo_data_out = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic fifo_push(input logic [7:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Runs one burst from the current cycle (c=0 is the start cycle).
    task automatic run_burst(input logic [7:0] len, input int budget, input int ready_from,
                             input bit rand_mode, input int push_from, input int extra_start_at);
        bit prev_busy = 1'b0;
        r_done_cyc = -1; r_rd_cnt = 0; r_first_rd = -1; r_last_rd = -1; r_rd_stall = 0;
        r_vld_cnt = 0; r_vld_first = -1; r_vld_last = -1;
        r_busy_at_done = 1'b0; r_busy_before = 1'b0; r_busy_ever = 1'b0;
        r_ws_at_done = 8'hxx; r_data_stall_end = 8'hxx;
        for (int c = 0; c < budget; c++) begin
            start     = (c == 0) || (c == extra_start_at);
            burst_len = (c == 0) ? len : 8'd7;
            if (rand_mode) m_ready = 1'($urandom_range(0, 1));
            else           m_ready = (c >= ready_from);
            if (c >= push_from && pending.size() > 0 &&
                (!rand_mode || $urandom_range(0, 1) == 1))
                fifo_push(pending.pop_front());
            @(negedge clk);
            if (fifo_rd_en) begin
                r_rd_cnt++;
                if (r_first_rd < 0) r_first_rd = c;
                r_last_rd = c;
                if (c < ready_from) r_rd_stall++;
            end
            if (m_valid && m_ready) begin
                r_vld_cnt++;
                if (r_vld_first < 0) r_vld_first = c;
                r_vld_last = c;
            end
            if (c == ready_from - 1) r_data_stall_end = m_data;
            if (busy) r_busy_ever = 1'b1;
            if (done) begin
                r_done_cyc     = c;
                r_busy_at_done = busy;
                r_busy_before  = prev_busy;
                r_ws_at_done   = words_sent;
                break;
            end
            prev_busy = busy;
            tick();
        end
        tick();
        start = 1'b0;
        if (r_done_cyc < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL burst_timeout: no done within %0d cycles, len=%0d", budget, len);
        end
    endtask

    // Scoreboard monitor: compares every accepted word and checks stream rules.
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        logic [7:0] w;
        if (rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (!(m_valid === 1'b1 && m_data === prev_data)) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%0b data=%0h, expected valid=1 data=%0h",
                             m_valid, m_data, prev_data);
                end
            end
            if (fifo_rd_en) begin
                n_cmp++;
                if (fifo_empty) begin
                    n_fail++;
                    $display("FAIL rd_on_empty: rd_en=1 with empty=1, expected rd_en=0");
                end
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, expected no word", m_data);
                end else begin
                    w = exp_q.pop_front();
                    if (m_data !== w) begin
                        n_fail++;
                        $display("FAIL stream_data: got %0h, expected %0h", m_data, w);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] len;
        // Reset values
        rst_n = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("reset_rd_en", fifo_rd_en, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_words_sent", words_sent, 0);
        tick();
        rst_n = 1'b0;
        tick();

        // Full-rate burst of 4
        for (int i = 0; i < 4; i++) fifo_push(8'h11 + 8'(i));
        run_burst(8'd4, 50, 0, 1'b0, 1000, -1);
        chk("t1_rd_count", r_rd_cnt, 4);
        chk("t1_first_rd", r_first_rd, 1);
        chk("t1_last_rd", r_last_rd, 4);
        chk("t1_vld_first", r_vld_first, 3);
        chk("t1_vld_last", r_vld_last, 6);
        chk("t1_done_cycle", r_done_cyc, 7);
        chk("t1_words_sent", r_ws_at_done, 4);
        chk("t1_busy_at_done", r_busy_at_done, 0);

        // Downstream stall for 10 cycles
        for (int i = 0; i < 4; i++) fifo_push(8'h11 + 8'(i));
        run_burst(8'd4, 60, 10, 1'b0, 1000, -1);
        chk("t2_rd_during_stall", r_rd_stall, 2);
        chk("t2_rd_count", r_rd_cnt, 4);
        chk("t2_data_in_stall", r_data_stall_end, 8'h11);
        chk("t2_vld_count", r_vld_cnt, 4);
        chk("t2_words_sent", r_ws_at_done, 4);

        // Empty FIFO, words arrive later
        pending = '{8'hA0, 8'hA1, 8'hA2};
        run_burst(8'd3, 60, 0, 1'b0, 5, -1);
        chk("t3_first_rd", r_first_rd, 5);
        chk("t3_rd_count", r_rd_cnt, 3);
        chk("t3_words_sent", r_ws_at_done, 3);
        chk("t3_busy_before_done", r_busy_before, 1);
        chk("t3_busy_at_done", r_busy_at_done, 0);

        // Zero-length burst
        run_burst(8'd0, 20, 0, 1'b0, 1000, -1);
        chk("t4_rd_count", r_rd_cnt, 0);
        chk("t4_done_cycle", r_done_cyc, 1);
        chk("t4_words_sent", r_ws_at_done, 0);
        chk("t4_busy_ever", r_busy_ever, 0);

        // start while busy is ignored
        fifo_push(8'h5A);
        fifo_push(8'h5B);
        run_burst(8'd2, 40, 0, 1'b0, 1000, 2);
        chk("t5_rd_count", r_rd_cnt, 2);
        chk("t5_done_cycle", r_done_cyc, 5);
        chk("t5_words_sent", r_ws_at_done, 2);
        fifo_push(8'h5C);
        run_burst(8'd1, 40, 0, 1'b0, 1000, -1);
        chk("t5_next_done_cycle", r_done_cyc, 4);
        chk("t5_next_words_sent", r_ws_at_done, 1);

        // Reset mid-burst with one word buffered and one in flight
        for (int i = 0; i < 4; i++) fifo_push(8'hC0 + 8'(i));
        m_ready   = 1'b0;
        start     = 1'b1;
        burst_len = 8'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_buffered_before_reset", m_valid, 1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_m_valid", m_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_words_sent", words_sent, 0);
        chk("t6_rd_en", fifo_rd_en, 0);
        chk("t6_done", done, 0);
        fq.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) fifo_push(8'hD0 + 8'(i));
        run_burst(8'd3, 40, 0, 1'b0, 1000, -1);
        chk("t6_after_done_cycle", r_done_cyc, 6);
        chk("t6_after_words_sent", r_ws_at_done, 3);

        // Randomized bursts with random arrival and backpressure
        for (int b = 0; b < 8; b++) begin
            len = 8'($urandom_range(1, 12));
            for (int i = 0; i < int'(len); i++) pending.push_back(8'($urandom));
            run_burst(len, 400, 0, 1'b1, 0, (b % 2 == 0) ? 3 : -1);
            chk("rand_rd_count", r_rd_cnt, 32'(len));
            chk("rand_words_sent", r_ws_at_done, len);
        end
        m_ready = 1'b0;
        tick();
        chk("all_words_delivered", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
